// File: rtl/multi_receiver_scheduler_pkg.sv
// Shared types and widths for the multi-receiver readout scheduler.
// Block layout: {decoded data, timestamp}, data in the upper bits.
package multi_receiver_scheduler_pkg;

    localparam int BLK_W  = 41;
    localparam int DATA_W = 17;
    localparam int TS_W   = 24;
    localparam int BN_W   = 8;

    typedef enum logic [2:0] {
        S_SCAN,
        S_REQ,
        S_WAIT,
        S_PRESENT,
        S_RELEASE,
        S_ABORT
    } sched_state_t;

    function automatic logic [DATA_W-1:0] blk_data(input logic [BLK_W-1:0] blk);
        return blk[TS_W +: DATA_W];
    endfunction

    function automatic logic [TS_W-1:0] blk_ts(input logic [BLK_W-1:0] blk);
        return blk[TS_W-1:0];
    endfunction

endpackage

// File: rtl/rr_pointer.sv
// Wrapping round-robin index: advances by one on adv, wraps from N-1 to 0.
module rr_pointer #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (adv)
            ptr <= (ptr == W'(N - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/multi_receiver_scheduler.sv
// Round-robin readout scheduler sharing one valid/ready stream between NB_RX receivers.
// Optional per-receiver abort counters (err_cnt_all) when SCHED_ERR_CNT_EN is defined.
module multi_receiver_scheduler #(
    parameter int NB_RX          = 4,
    parameter int BLK_W          = multi_receiver_scheduler_pkg::BLK_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk_96MHz,
    input  logic                       reset_n,
    input  logic [NB_RX*8-1:0]         avl_blocks_nb_all,
    input  logic [NB_RX*BLK_W-1:0]     block_wanted_all,
    input  logic [NB_RX-1:0]           data_ready_all,
    output logic [NB_RX*8-1:0]         block_wanted_number_all,
    output logic [BLK_W-1:0]           out_block,
    output logic [$clog2(NB_RX)-1:0]   out_rx_id,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef SCHED_ERR_CNT_EN
    output logic [NB_RX*8-1:0]         err_cnt_all,
`endif
    output logic                       timeout_pulse
);
    import multi_receiver_scheduler_pkg::*;

    localparam int ID_W  = $clog2(NB_RX);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t      state, state_nxt;
    logic [ID_W-1:0]   ptr;
    logic              ptr_adv;
    logic [BN_W-1:0]   idx, idx_nxt, burst_len, burst_nxt;
    logic [TMO_W-1:0]  cnt, cnt_nxt;
    logic              seen_low, seen_nxt;
    logic [BLK_W-1:0]  blk_nxt;
    logic [ID_W-1:0]   id_nxt;
    logic              last_nxt, vld_nxt;
    logic [BN_W-1:0]   avl_cur;
    logic [BLK_W-1:0]  blk_cur;
    logic              rdy_cur, tmo_hit;

    rr_pointer #(.N(NB_RX), .W(ID_W)) u_ptr (
        .clk   (clk_96MHz),
        .rst_n (reset_n),
        .adv   (ptr_adv),
        .ptr   (ptr)
    );

    assign avl_cur       = avl_blocks_nb_all[int'(ptr)*BN_W +: BN_W];
    assign blk_cur       = block_wanted_all[int'(ptr)*BLK_W +: BLK_W];
    assign rdy_cur       = data_ready_all[ptr];
    assign tmo_hit       = (cnt == TMO_W'(TIMEOUT_CYCLES));
    assign timeout_pulse = (state == S_ABORT);

    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_SCAN;
            idx       <= '0;
            burst_len <= '0;
            cnt       <= '0;
            seen_low  <= 1'b0;
            out_block <= '0;
            out_rx_id <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            burst_len <= burst_nxt;
            cnt       <= cnt_nxt;
            seen_low  <= seen_nxt;
            out_block <= blk_nxt;
            out_rx_id <= id_nxt;
            out_last  <= last_nxt;
            out_valid <= vld_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        burst_nxt = burst_len;
        cnt_nxt   = cnt;
        seen_nxt  = seen_low;
        blk_nxt   = out_block;
        id_nxt    = out_rx_id;
        last_nxt  = out_last;
        vld_nxt   = out_valid;
        ptr_adv   = 1'b0;
        unique case (state)
            S_SCAN: begin
                if (avl_cur != '0) begin
                    burst_nxt = avl_cur;
                    idx_nxt   = 8'd1;
                    state_nxt = S_REQ;
                end else begin
                    ptr_adv = 1'b1;
                end
            end
            S_REQ: begin
                // A ready level left over from the previous block only counts once it has dropped.
                cnt_nxt   = '0;
                seen_nxt  = (idx == 8'd1) || !rdy_cur;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (rdy_cur && seen_low) begin
                    blk_nxt   = blk_cur;
                    id_nxt    = ptr;
                    last_nxt  = (idx == burst_len);
                    vld_nxt   = 1'b1;
                    state_nxt = S_PRESENT;
                end else begin
                    if (!rdy_cur)
                        seen_nxt = 1'b1;
                    if (tmo_hit)
                        state_nxt = S_ABORT;
                    else
                        cnt_nxt = cnt + 1'b1;
                end
            end
            S_PRESENT: begin
                if (out_ready) begin
                    vld_nxt = 1'b0;
                    if (idx < burst_len) begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = S_REQ;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (!rdy_cur || tmo_hit) begin
                    ptr_adv   = 1'b1;
                    state_nxt = S_SCAN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_ABORT: begin
                ptr_adv   = 1'b1;
                state_nxt = S_SCAN;
            end
            default: state_nxt = S_SCAN;
        endcase
    end

    // Only the receiver being served sees a nonzero block number.
    always_comb begin
        block_wanted_number_all = '0;
        if (state == S_REQ || state == S_WAIT || state == S_PRESENT)
            block_wanted_number_all[int'(ptr)*BN_W +: BN_W] = idx;
    end

`ifdef SCHED_ERR_CNT_EN
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n)
            err_cnt_all <= '0;
        else if (state == S_ABORT && err_cnt_all[int'(ptr)*BN_W +: BN_W] != 8'hFF)
            err_cnt_all[int'(ptr)*BN_W +: BN_W] <= err_cnt_all[int'(ptr)*BN_W +: BN_W] + 1'b1;
    end
`endif

endmodule

// File: tb/tb_multi_receiver_scheduler.sv
// Self-checking bench for multi_receiver_scheduler: table-driven burst scenarios plus
// hand-written stall, timeout, stale-ready and mid-burst reset sequences.
module tb_multi_receiver_scheduler;

    localparam int NB_RX = 4;
    localparam int BLK_W = 41;
    localparam int ID_W  = 2;

    logic                   clk_96MHz = 1'b0;
    logic                   reset_n   = 1'b0;
    logic [NB_RX*8-1:0]     avl_blocks_nb_all;
    logic [NB_RX*BLK_W-1:0] block_wanted_all;
    logic [NB_RX-1:0]       data_ready_all;
    logic [NB_RX*8-1:0]     block_wanted_number_all;
    logic [BLK_W-1:0]       out_block;
    logic [ID_W-1:0]        out_rx_id;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;
    logic                   timeout_pulse;
`ifdef SCHED_ERR_CNT_EN
    logic [NB_RX*8-1:0]     err_cnt_all;
`endif

    multi_receiver_scheduler #(.NB_RX(NB_RX), .BLK_W(BLK_W), .TIMEOUT_CYCLES(255)) dut (
        .clk_96MHz               (clk_96MHz),
        .reset_n                 (reset_n),
        .avl_blocks_nb_all       (avl_blocks_nb_all),
        .block_wanted_all        (block_wanted_all),
        .data_ready_all          (data_ready_all),
        .block_wanted_number_all (block_wanted_number_all),
        .out_block               (out_block),
        .out_rx_id               (out_rx_id),
        .out_last                (out_last),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
`ifdef SCHED_ERR_CNT_EN
        .err_cnt_all             (err_cnt_all),
`endif
        .timeout_pulse           (timeout_pulse)
    );

    always #5 clk_96MHz = ~clk_96MHz;

    typedef struct {
        int               rx;
        logic [BLK_W-1:0] blk;
        bit               last;
    } rec_t;

    typedef struct {
        int rx;
        int n;
        bit last;
    } xexp_t;

    typedef struct {
        logic [31:0] avl;
        int          lat;
        int          first;
        int          nx;
    } sc_t;

    rec_t  xq[$];
    xexp_t ex[13];
    sc_t   sc[4];

    int checks = 0;
    int failures = 0;
    int valid_seen = 0;
    int nz_seen = 0;
    int multi_nz = 0;
    int tp_seen = 0;

    logic [7:0] last_num [NB_RX];
    int         rsp_cnt  [NB_RX];
    bit         stuck    [NB_RX];
    bit         sticky   [NB_RX];
    int         rsp_lat = 2;

    function automatic logic [BLK_W-1:0] blk_val(input int rx, input logic [7:0] n);
        logic [7:0] r8;
        r8 = 8'(rx);
        return {r8, n, 25'h1ABCDE};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Behavioural receiver: hands over its blocks once requested, answers after rsp_lat cycles.
    task automatic respond();
        for (int i = 0; i < NB_RX; i++) begin
            logic [7:0] num;
            num = block_wanted_number_all[i*8 +: 8];
            if (num != 8'd0)
                avl_blocks_nb_all[i*8 +: 8] = 8'd0;
            if (num == 8'd0) begin
                data_ready_all[i] = 1'b0;
                rsp_cnt[i] = 0;
            end else if (sticky[i] && data_ready_all[i]) begin
                rsp_cnt[i] = rsp_cnt[i];
            end else if (num != last_num[i]) begin
                data_ready_all[i] = 1'b0;
                rsp_cnt[i] = 0;
                block_wanted_all[i*BLK_W +: BLK_W] = blk_val(i, num);
            end else if (!stuck[i]) begin
                if (rsp_cnt[i] >= rsp_lat)
                    data_ready_all[i] = 1'b1;
                else
                    rsp_cnt[i]++;
            end
            last_num[i] = num;
        end
    endtask

    task automatic tick();
        @(posedge clk_96MHz);
        #1;
        respond();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_xfers(input int base, input int n, input int budget);
        for (int c = 0; c < budget && (xq.size() - base) < n; c++)
            tick();
    endtask

    always @(negedge clk_96MHz) begin : mon
        int nz;
        if (out_valid && out_ready)
            xq.push_back('{rx: int'(out_rx_id), blk: out_block, last: out_last});
        if (out_valid)
            valid_seen++;
        if (timeout_pulse)
            tp_seen++;
        nz = 0;
        for (int i = 0; i < NB_RX; i++)
            if (block_wanted_number_all[i*8 +: 8] != 8'd0)
                nz++;
        if (nz > 0)
            nz_seen++;
        if (nz > 1)
            multi_nz++;
    end

    initial begin
        int base, v0, z0, t0, cnt, errs;
        logic [BLK_W-1:0] hb;
        logic [ID_W-1:0]  hid;
        logic             hl;

        sc[0] = '{32'h0003_0000, 2, 0, 3};
        sc[1] = '{32'h0000_0102, 1, 3, 3};
        sc[2] = '{32'h0100_0200, 0, 6, 3};
        sc[3] = '{32'h0101_0101, 3, 9, 4};
        ex[0]  = '{2, 1, 0}; ex[1]  = '{2, 2, 0}; ex[2]  = '{2, 3, 1};
        ex[3]  = '{0, 1, 0}; ex[4]  = '{0, 2, 1}; ex[5]  = '{1, 1, 1};
        ex[6]  = '{1, 1, 0}; ex[7]  = '{1, 2, 1}; ex[8]  = '{3, 1, 1};
        ex[9]  = '{0, 1, 1}; ex[10] = '{1, 1, 1}; ex[11] = '{2, 1, 1};
        ex[12] = '{3, 1, 1};

        avl_blocks_nb_all = '0;
        block_wanted_all  = '0;
        data_ready_all    = '0;
        out_ready         = 1'b1;
        for (int i = 0; i < NB_RX; i++) begin
            last_num[i] = 8'd0; rsp_cnt[i] = 0; stuck[i] = 1'b0; sticky[i] = 1'b0;
        end

        // Reset state
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_timeout", 64'(timeout_pulse), 64'd0);
        chk("rst_out_block", 64'(out_block), 64'd0);
        chk("rst_out_rx_id", 64'(out_rx_id), 64'd0);
        chk("rst_numbers", 64'(block_wanted_number_all), 64'd0);
        reset_n = 1'b1;

        // Idle scan
        v0 = valid_seen; z0 = nz_seen;
        repeat (1000) tick();
        chk("idle_valid_cycles", 64'(valid_seen - v0), 64'd0);
        chk("idle_number_cycles", 64'(nz_seen - z0), 64'd0);

        // Table-driven bursts
        for (int s = 0; s < 4; s++) begin
            do_reset();
            rsp_lat = sc[s].lat;
            base = xq.size();
            avl_blocks_nb_all = sc[s].avl;
            wait_xfers(base, sc[s].nx, 600);
            repeat (20) tick();
            chk($sformatf("sc%0d_count", s), 64'(xq.size() - base), 64'(sc[s].nx));
            for (int k = 0; k < sc[s].nx; k++) begin
                if (base + k < xq.size()) begin
                    xexp_t e;
                    e = ex[sc[s].first + k];
                    chk($sformatf("sc%0d_x%0d_rx", s, k), 64'(xq[base+k].rx), 64'(e.rx));
                    chk($sformatf("sc%0d_x%0d_blk", s, k), 64'(xq[base+k].blk), 64'(blk_val(e.rx, 8'(e.n))));
                    chk($sformatf("sc%0d_x%0d_last", s, k), 64'(xq[base+k].last), 64'(e.last));
                end
            end
            chk($sformatf("sc%0d_numbers_idle", s), 64'(block_wanted_number_all), 64'd0);
            chk($sformatf("sc%0d_out_valid_idle", s), 64'(out_valid), 64'd0);
        end
        rsp_lat = 2;

        // Back-pressure: out_ready low for 20 cycles while a block is presented
        do_reset();
        out_ready = 1'b0;
        avl_blocks_nb_all[15:8] = 8'd1;
        for (int c = 0; c < 100 && !out_valid; c++) tick();
        chk("stall_valid_rise", 64'(out_valid), 64'd1);
        hb = out_block; hid = out_rx_id; hl = out_last;
        chk("stall_rx", 64'(hid), 64'd1);
        chk("stall_blk", 64'(hb), 64'(blk_val(1, 8'd1)));
        chk("stall_last", 64'(hl), 64'd1);
        errs = 0;
        base = xq.size();
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid !== 1'b1 || out_block !== hb || out_rx_id !== hid || out_last !== hl)
                errs++;
        end
        chk("stall_stable", 64'(errs), 64'd0);
        out_ready = 1'b1;
        repeat (30) tick();
        chk("stall_one_xfer", 64'(xq.size() - base), 64'd1);
        chk("stall_valid_drop", 64'(out_valid), 64'd0);

        // Timeout on rx3 with data_ready stuck low
        do_reset();
        stuck[3] = 1'b1;
        v0 = valid_seen; t0 = tp_seen;
        avl_blocks_nb_all[31:24] = 8'd1;
        for (int c = 0; c < 50 && block_wanted_number_all[31:24] == 8'd0; c++) tick();
        cnt = 0;
        while (block_wanted_number_all[31:24] != 8'd0 && cnt < 400) begin
            cnt++;
            tick();
        end
        chk("tmo_request_cycles", 64'(cnt), 64'd257);
        chk("tmo_pulse_high", 64'(timeout_pulse), 64'd1);
        avl_blocks_nb_all[7:0] = 8'd1;
        tick();
        chk("tmo_pulse_one_cycle", 64'(timeout_pulse), 64'd0);
`ifdef SCHED_ERR_CNT_EN
        chk("tmo_err_cnt3", 64'(err_cnt_all[31:24]), 64'd1);
`endif
        tick();
        chk("tmo_next_is_rx0", 64'(block_wanted_number_all[7:0]), 64'd1);
        chk("tmo_no_valid", 64'(valid_seen - v0), 64'd0);
        chk("tmo_pulse_count", 64'(tp_seen - t0), 64'd1);
        stuck[3] = 1'b0;
        base = xq.size();
        wait_xfers(base, 1, 100);
        chk("tmo_rx0_xfer", 64'(xq.size() - base), 64'd1);
        if (xq.size() > base)
            chk("tmo_rx0_id", 64'(xq[base].rx), 64'd0);

        // Stale ready: rx1 holds data_ready high across the number change
        do_reset();
        sticky[1] = 1'b1;
        t0 = tp_seen;
        base = xq.size();
        avl_blocks_nb_all[15:8] = 8'd2;
        for (int c = 0; c < 400 && tp_seen == t0; c++) tick();
        repeat (5) tick();
        chk("stale_xfers", 64'(xq.size() - base), 64'd1);
        if (xq.size() > base) begin
            chk("stale_x0_blk", 64'(xq[base].blk), 64'(blk_val(1, 8'd1)));
            chk("stale_x0_last", 64'(xq[base].last), 64'd0);
        end
        chk("stale_timeout", 64'(tp_seen - t0), 64'd1);
        sticky[1] = 1'b0;

        // Reset asserted while a block is presented
        do_reset();
        out_ready = 1'b0;
        avl_blocks_nb_all[23:16] = 8'd1;
        for (int c = 0; c < 100 && !out_valid; c++) tick();
        chk("midrst_valid_before", 64'(out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid_async", 64'(out_valid), 64'd0);
        chk("midrst_numbers", 64'(block_wanted_number_all), 64'd0);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        avl_blocks_nb_all[7:0] = 8'd1;
        tick();
        chk("midrst_scan_rx0", 64'(block_wanted_number_all[7:0]), 64'd1);
        base = xq.size();
        wait_xfers(base, 1, 100);
        chk("midrst_xfer", 64'(xq.size() - base), 64'd1);
        if (xq.size() > base)
            chk("midrst_xfer_rx", 64'(xq[base].rx), 64'd0);

        chk("single_number_active", 64'(multi_nz), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_receiver_scheduler.md
Name: multi_receiver_scheduler

Overview:
- Round-robin readout scheduler that shares one downstream consumer (SPI/UART framer) between NB_RX single_receiver_manager instances.
- Scans each receiver's avl_blocks_nb and fetches that receiver's decoded blocks one at a time through its block_wanted_number / block_wanted / data_ready port.
- Forwards each block, tagged with its receiver index, over a valid/ready stream.
- Sits between the receiver array and the host-link framer.

Parameters:
- NB_RX, 4, number of receivers served (2..16).
- BLK_W, 41, block width (17-bit decoded data + 24-bit timestamp).
- TIMEOUT_CYCLES, 255, max cycles to wait on data_ready edges before a receiver is abandoned for this round.

Ports:
- clk_96MHz  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- avl_blocks_nb_all  in  NB_RX*8  per-receiver available block count; receiver i at [8i+7:8i].
- block_wanted_all  in  NB_RX*BLK_W  per-receiver selected block.
- data_ready_all  in  NB_RX  per-receiver "block_wanted valid for current number".
- block_wanted_number_all  out  NB_RX*8  per-receiver block index request; 0 = no request / release.
- out_block  out  BLK_W  forwarded block.
- out_rx_id  out  clog2(NB_RX)  source receiver index.
- out_last  out  1  block is the last of this receiver's burst.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from consumer.
- timeout_pulse  out  1  one-cycle pulse when a receiver is abandoned.

Behaviour:
- Reset values: all block_wanted_number fields = 0; out_valid, out_last, timeout_pulse = 0; out_block = 0; out_rx_id = 0; round-robin pointer = 0; FSM = SCAN.
- Only the current receiver's number field is ever nonzero; all others are held at 0.
- FSM states:
  - SCAN: examine receiver at ptr. If avl > 0, latch burst_len = avl (snapshot; later increments are ignored until the next visit), set idx = 1, go to REQ. Else ptr = ptr+1 (wraps at NB_RX-1 → 0) and stay in SCAN. One receiver per cycle.
  - REQ: drive number[ptr] = idx, clear the timeout counter, go to WAIT.
  - WAIT: on data_ready[ptr] = 1, register block_wanted[ptr] into out_block, set out_rx_id = ptr and out_last = (idx == burst_len), assert out_valid, go to PRESENT. If the counter reaches TIMEOUT_CYCLES first, go to ABORT.
  - PRESENT: hold out_* stable while out_valid && !out_ready. On the handshake cycle drop out_valid next cycle. If idx < burst_len, go to REQ with idx+1. Else go to RELEASE.
  - RELEASE: drive number[ptr] = 0, wait for data_ready[ptr] = 0 (bounded by the timeout), then ptr+1 (wrap) and go to SCAN.
  - ABORT: pulse timeout_pulse for 1 cycle, drive number[ptr] = 0, then ptr+1 and go to SCAN. The partial burst is dropped; blocks already forwarded stand. out_last is never emitted for an aborted burst.
- Every new request begins with data_ready low. If data_ready[ptr] is already 1 on entry to WAIT from REQ with idx > 1, that level counts only after it was seen low at least once since REQ (stale-ready guard).
- Latency: data_ready high → out_valid high = 1 cycle. Handshake → next REQ = 1 cycle.
- Best case per block is 3 cycles plus the receiver's response time.
- A timeout counter overflow is not possible: it saturates at TIMEOUT_CYCLES.
- Fairness: at most one burst (≤ 255 blocks) per receiver per visit; the pointer always advances after a burst or abort.
- A reset_n assertion mid-burst returns everything to reset values immediately; any pending out_valid is dropped.
- A simultaneous avl change and SCAN sample uses the registered avl of that cycle.

Optional Feature:
- SCHED_ERR_CNT_EN:
  - Defined: adds output err_cnt_all (NB_RX*8), one saturating 8-bit counter per receiver, incremented on each ABORT of that receiver and cleared by reset_n only.
  - Undefined: port absent, no counters; timeout_pulse is unchanged either way.

Decomposition:
- Shared package holds:
  - FSM state encoding (SCAN, REQ, WAIT, PRESENT, RELEASE, ABORT).
  - BLK_W = 41, with field offsets DATA_W = 17 and TS_W = 24.
  - The 8-bit block-number width.
- One natural sub-module, rr_pointer: wrapping index counter with advance strobe, reusable by the host framer.

Test Plan:
- Reset, all avl = 0 → FSM cycles through SCAN; all number fields 0; out_valid never rises over 1000 cycles.
- rx2 avl = 3, ready responder at 2-cycle latency, out_ready = 1 → three blocks with out_rx_id = 2 and idx 1, 2, 3; out_last only on the third; then number[2] = 0.
- rx0 avl = 2 and rx1 avl = 1 together → order rx0 b1, rx0 b2 (last), rx1 b1 (last); never two number fields nonzero.
- out_ready held low 20 cycles during PRESENT → out_block, out_rx_id, out_last stable and out_valid high throughout; exactly one transfer.
- rx3 data_ready stuck low → timeout_pulse after 256 cycles in WAIT; ptr moves to rx0. With SCHED_ERR_CNT_EN, err_cnt[3] = 1.
- reset_n low mid-PRESENT → out_valid = 0 asynchronously; after release, scan restarts at rx0.
